// File: rtl/sram_arb_pkg.sv
// Shared widths, grant encoding and write-buffer types for the SRAM arbiter.
package sram_arb_pkg;

    localparam int ADR_W = 18;
    localparam int DAT_W = 32;
    localparam int BEN_W = 4;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_VID   = 2'd1,
        GNT_RD    = 2'd2,
        GNT_DRAIN = 2'd3
    } grant_e;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_ONE   = 2'd1,
        WB_FULL  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [BEN_W-1:0] ben;
        logic [DAT_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/sram_arb_wbuf.sv
// Two-entry posted-write FIFO with shift-down storage and an address-hit compare.
// Handshake: push and pop are single-cycle strobes; the caller never pushes into FULL without a pop.
module sram_wbuf
    import sram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        push_entry,
    input  logic [ADR_W-1:0] match_adr,
    output wb_entry_t        head,
    output logic             empty,
    output logic             full,
    output logic             hit,
    output wb_state_e        state
);

    wb_state_e state_nx;
    wb_entry_t e0;
    wb_entry_t e1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WB_EMPTY;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WB_EMPTY: if (push) state_nx = WB_ONE;
            WB_ONE: begin
                if (push && !pop)      state_nx = WB_FULL;
                else if (pop && !push) state_nx = WB_EMPTY;
            end
            WB_FULL:  if (pop && !push) state_nx = WB_ONE;
            default:  state_nx = WB_EMPTY;
        endcase
    end

    // e0 is always the oldest entry; a pop shifts e1 down into it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0 <= '0;
            e1 <= '0;
        end else begin
            case (state)
                WB_EMPTY: if (push) e0 <= push_entry;
                WB_ONE: begin
                    if (push && pop) e0 <= push_entry;
                    else if (push)   e1 <= push_entry;
                end
                WB_FULL: begin
                    if (pop) begin
                        e0 <= e1;
                        if (push) e1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = e0;
    assign empty = (state == WB_EMPTY);
    assign full  = (state == WB_FULL);
    assign hit   = ((state != WB_EMPTY) && (e0.adr == match_adr)) ||
                   ((state == WB_FULL)  && (e1.adr == match_adr));

endmodule

// File: rtl/sram_arb.sv
// Single-port SRAM arbiter: video reads first, then CPU reads, then posted-write drain.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int WBDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vid_req,
    input  logic [ADR_W-1:0] vid_adr,
    output logic [DAT_W-1:0] vid_data,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [BEN_W-1:0] cpu_ben,
    input  logic [DAT_W-1:0] cpu_wdata,
    output logic [DAT_W-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic [ADR_W-1:0] sram_adr,
    output logic [DAT_W-1:0] sram_dout,
    input  logic [DAT_W-1:0] sram_din,
    output logic             sram_oe,
    output logic             sram_we,
    output logic [BEN_W-1:0] sram_ben,
    output logic [15:0]      stall_cnt
);

    if (WBDEPTH != 2) begin : g_bad_depth
        $error("sram_arb supports only WBDEPTH == 2");
    end

    grant_e           grant;
    wb_state_e        wb_state;
    wb_entry_t        head;
    wb_entry_t        push_entry;
    logic             wb_empty;
    logic             wb_full;
    logic             wb_hit;
    logic             push;
    logic             pop;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] adr_nx;

    assign push_entry = '{adr: cpu_adr, ben: cpu_ben, data: cpu_wdata};

    sram_wbuf u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .match_adr  (cpu_adr),
        .head       (head),
        .empty      (wb_empty),
        .full       (wb_full),
        .hit        (wb_hit),
        .state      (wb_state)
    );

    always_comb begin
        grant    = GNT_IDLE;
        adr_nx   = adr_q;
        sram_ben = '0;
        sram_we  = 1'b0;
        sram_oe  = 1'b0;
        if (vid_req) begin
            grant    = GNT_VID;
            adr_nx   = vid_adr;
            sram_ben = 4'hF;
        end else if (cpu_rd && !wb_hit) begin
            grant    = GNT_RD;
            adr_nx   = cpu_adr;
            sram_ben = 4'hF;
        end else if (!wb_empty) begin
            grant    = GNT_DRAIN;
            adr_nx   = head.adr;
            sram_ben = head.ben;
            // Never write while reset is held, even for a single delta.
            sram_we  = rst;
            sram_oe  = 1'b1;
        end
    end

    assign pop       = (grant == GNT_DRAIN);
    assign push      = cpu_wr && !(wb_full && !pop);
    assign cpu_stall = (cpu_rd && (grant != GNT_RD)) || (cpu_wr && wb_full && !pop);

    assign sram_adr  = adr_nx;
    assign sram_dout = head.data;
    assign vid_data  = sram_din;
    assign cpu_rdata = sram_din;

    // Address register keeps the pads steady through idle slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) adr_q <= '0;
        else      adr_q <= adr_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              stall_cnt <= '0;
        else if (cpu_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: grant priority, write buffer ordering, reset and stall counter.
module tb_sram_arb;

    logic        clk;
    logic        rst;
    logic        vid_req;
    logic [17:0] vid_adr;
    logic [31:0] vid_data;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [17:0] cpu_adr;
    logic [3:0]  cpu_ben;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [17:0] sram_adr;
    logic [31:0] sram_dout;
    logic [31:0] sram_din;
    logic        sram_oe;
    logic        sram_we;
    logic [3:0]  sram_ben;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [53:0] exp_q[$];
    logic [53:0] wr_log[$];

    sram_arb #(.WBDEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_adr   (vid_adr),
        .vid_data  (vid_data),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_adr   (cpu_adr),
        .cpu_ben   (cpu_ben),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .sram_adr  (sram_adr),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_ben  (sram_ben),
        .stall_cnt (stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // every SRAM write as seen at the clock edge that ends its cycle
    always @(posedge clk) begin
        if (sram_we) wr_log.push_back({sram_adr, sram_ben, sram_dout});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [17:0] a, input logic [3:0] b, input logic [31:0] d);
        cpu_wr    = 1'b1;
        cpu_adr   = a;
        cpu_ben   = b;
        cpu_wdata = d;
        exp_q.push_back({a, b, d});
    endtask

    initial begin
        rst = 1'b0; vid_req = 1'b0; vid_adr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_adr = '0; cpu_ben = '0; cpu_wdata = '0; sram_din = '0;

        // reset state
        @(negedge clk); #1;
        chk("rst_we", sram_we, 1'b0);
        chk("rst_oe", sram_oe, 1'b0);
        chk("rst_ben", sram_ben, 4'h0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_adr", sram_adr, 18'h0);
        chk("rst_cnt", stall_cnt, 16'h0);
        next_cyc();
        rst = 1'b1;

        // video only
        vid_req = 1'b1; vid_adr = 18'h37FC0; sram_din = 32'hA5A5_0F0F; #1;
        chk("vid_adr", sram_adr, 18'h37FC0);
        chk("vid_data", vid_data, 32'hA5A5_0F0F);
        chk("vid_we", sram_we, 1'b0);
        chk("vid_ben", sram_ben, 4'hF);
        next_cyc();
        vid_req = 1'b0; #1;
        chk("idle_hold_adr", sram_adr, 18'h37FC0);
        chk("idle_oe", sram_oe, 1'b0);
        chk("idle_ben", sram_ben, 4'h0);
        next_cyc();

        // collision: VID wins, CPU read stalls one cycle then gets RD
        vid_req = 1'b1; vid_adr = 18'h00300; cpu_rd = 1'b1; cpu_adr = 18'h00200; #1;
        chk("col_adr_vid", sram_adr, 18'h00300);
        chk("col_stall", cpu_stall, 1'b1);
        next_cyc();
        vid_req = 1'b0; sram_din = 32'hCAFE_0200; #1;
        chk("col_adr_rd", sram_adr, 18'h00200);
        chk("col_rd_stall", cpu_stall, 1'b0);
        chk("col_rdata", cpu_rdata, 32'hCAFE_0200);
        chk("col_cnt", stall_cnt, 16'd1);
        next_cyc();
        cpu_rd = 1'b0;

        // write then read of the same address: one-cycle hit stall while it drains
        cpu_write(18'h00100, 4'h3, 32'h1234_5678); #1;
        chk("wr_stall", cpu_stall, 1'b0);
        next_cyc();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_adr = 18'h00100; #1;
        chk("hit_stall", cpu_stall, 1'b1);
        chk("drain_we", sram_we, 1'b1);
        chk("drain_oe", sram_oe, 1'b1);
        chk("drain_ben", sram_ben, 4'h3);
        chk("drain_adr", sram_adr, 18'h00100);
        chk("drain_dout", sram_dout, 32'h1234_5678);
        next_cyc();
        sram_din = 32'h1234_5678; #1;
        chk("raw_stall", cpu_stall, 1'b0);
        chk("raw_adr", sram_adr, 18'h00100);
        chk("raw_we", sram_we, 1'b0);
        chk("raw_rdata", cpu_rdata, 32'h1234_5678);
        chk("raw_cnt", stall_cnt, 16'd2);
        next_cyc();
        cpu_rd = 1'b0;

        // buffer full: three back-to-back writes, video holds the slot for two cycles
        cpu_write(18'h00010, 4'hF, 32'h1111_1111); #1;
        chk("bf_w1_stall", cpu_stall, 1'b0);
        next_cyc();
        vid_req = 1'b1; vid_adr = 18'h00400;
        cpu_write(18'h00011, 4'h1, 32'h2222_2222); #1;
        chk("bf_w2_stall", cpu_stall, 1'b0);
        next_cyc();
        cpu_write(18'h00012, 4'h8, 32'h3333_3333); #1;
        chk("bf_w3_stall", cpu_stall, 1'b1);
        chk("bf_w3_we", sram_we, 1'b0);
        next_cyc();
        vid_req = 1'b0; #1;
        chk("bf_w3_accept", cpu_stall, 1'b0);
        chk("bf_d1_adr", sram_adr, 18'h00010);
        chk("bf_d1_dout", sram_dout, 32'h1111_1111);
        next_cyc();
        cpu_wr = 1'b0; #1;
        chk("bf_d2_adr", sram_adr, 18'h00011);
        chk("bf_d2_ben", sram_ben, 4'h1);
        next_cyc();
        #1;
        chk("bf_d3_adr", sram_adr, 18'h00012);
        chk("bf_d3_ben", sram_ben, 4'h8);
        next_cyc();
        #1;
        chk("bf_empty_oe", sram_oe, 1'b0);
        chk("bf_cnt", stall_cnt, 16'd3);
        next_cyc();

        // reset with two entries buffered (these writes must never reach the SRAM)
        vid_req = 1'b1;
        cpu_wr = 1'b1; cpu_adr = 18'h00020; cpu_ben = 4'hF; cpu_wdata = 32'h4444_4444; #1;
        chk("rs_w4_stall", cpu_stall, 1'b0);
        next_cyc();
        cpu_adr = 18'h00021; cpu_wdata = 32'h5555_5555; #1;
        chk("rs_w5_stall", cpu_stall, 1'b0);
        next_cyc();
        vid_req = 1'b0; cpu_wr = 1'b0; rst = 1'b0; #1;
        chk("rs_we_now", sram_we, 1'b0);
        chk("rs_cnt_now", stall_cnt, 16'd0);
        next_cyc();
        next_cyc();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rs_no_drain_oe", sram_oe, 1'b0);
            chk("rs_no_drain_we", sram_we, 1'b0);
            next_cyc();
        end
        cpu_rd = 1'b1; cpu_adr = 18'h00020; #1;
        chk("rs_no_hit", cpu_stall, 1'b0);
        chk("rs_rd_adr", sram_adr, 18'h00020);
        chk("rs_cnt", stall_cnt, 16'd0);
        next_cyc();

        // stall counter saturation: video and CPU read every cycle
        vid_req = 1'b1; vid_adr = 18'h00500; cpu_rd = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_100", stall_cnt, 16'd100);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_max", stall_cnt, 16'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_hold", stall_cnt, 16'hFFFF);
        vid_req = 1'b0; cpu_rd = 1'b0;
        next_cyc();
        #1;
        chk("sat_cnt_idle", stall_cnt, 16'hFFFF);

        // scoreboard: SRAM writes in issue order, none stale
        chk("wr_count", wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size()) chk("wr_order", wr_log[i], exp_q[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arb.md
# sram_arb

Single-port SRAM arbiter sitting directly upstream of the 1024x768 display controller. It owns the external 256K x 32 asynchronous SRAM and shares it between the video refresh port, which has absolute priority, and the CPU port. CPU writes are posted into a 2-entry write buffer so that video slots rarely stall the processor. Video reads are answered combinationally in the request cycle, as the display controller requires.

## Interface
Parameters:
- WBDEPTH, 2: posted-write buffer entries; only 2 is supported.

Ports:
- clk  in  1  system/SRAM clock; same clock as the video request logic.
- rst  in  1  asynchronous, active-low reset.
- vid_req  in  1  video read request; one-cycle pulse, at most one per 8 clk.
- vid_adr  in  18  video word address.
- vid_data  out  32  SRAM read data; valid in every cycle where vid_req=1.
- cpu_rd  in  1  CPU read; held until accepted.
- cpu_wr  in  1  CPU write; held until accepted; mutually exclusive with cpu_rd.
- cpu_adr  in  18  CPU word address.
- cpu_ben  in  4  CPU byte enables; active high.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data; valid when cpu_rd=1 and cpu_stall=0.
- cpu_stall  out  1  1 = CPU request not accepted this cycle.
- sram_adr  out  18  SRAM address.
- sram_dout  out  32  SRAM write data.
- sram_din  in  32  SRAM read data (pad input).
- sram_oe  out  1  1 = drive sram_dout onto the pads.
- sram_we  out  1  1 = write cycle; the top level gates it into the low clock half.
- sram_ben  out  4  byte enables for the current cycle.
- stall_cnt  out  16  saturating count of cycles with cpu_stall=1.

## Operation
- Each cycle exactly one SRAM slot is granted, in priority order:
  1. VID: vid_req=1. sram_adr=vid_adr, read; sram_ben=4'hF.
  2. RD: cpu_rd=1 with no address hit in the write buffer. sram_adr=cpu_adr, read.
  3. DRAIN: buffer non-empty. Write the oldest entry.
  4. IDLE: sram_adr holds its last value; sram_we=0; sram_oe=0.
- vid_data and cpu_rdata are both combinational copies of sram_din.
- cpu_stall=1 when either:
  - cpu_rd=1 and the slot is not RD; or
  - cpu_wr=1 and the buffer is full with no DRAIN in this cycle.
- Write acceptance: cpu_wr accepted pushes {adr, ben, wdata} at the tail. A DRAIN plus a push in the same cycle with the buffer full is legal: the count stays at 2.
- Read hit: cpu_adr equals the address of any valid entry. The read stalls until that entry has drained, which guarantees read-after-write order. No forwarding.
- Entries drain strictly in FIFO order. Two entries at the same address are both written, in order.
- Buffer state machine has states EMPTY, ONE, FULL:
  - push without drain moves up one state;
  - drain without push moves down one state;
  - push and drain together keep the state.
- stall_cnt increments on every stalled cycle and saturates at 16'hFFFF.

## Timing
- Reads have zero latency: data is valid in the same cycle as the slot, and sram_adr is combinational from the grant.
- A write is visible in SRAM at the end of its DRAIN cycle, no earlier than 1 cycle after acceptance.
- sram_we, sram_oe, sram_dout and sram_ben are combinational from the grant and the buffer head.
- The buffer, the state and stall_cnt are registers.
- Reset values:
  - buffer EMPTY; stall_cnt=0; sram_adr=0.
  - with no requests: sram_we=0, sram_oe=0, sram_ben=0, cpu_stall=0.
- Reset asserted mid-operation discards buffered writes. No SRAM write occurs while rst=0: sram_we is forced to 0 combinationally.
- With vid_req every 8th cycle and continuous CPU writes, the buffer never stays full for more than 1 cycle.

## Structure
- A shared package holds:
  - address width (18) and data width (32) constants;
  - the grant encoding GNT_IDLE/GNT_VID/GNT_RD/GNT_DRAIN;
  - the buffer state encoding.
- One natural sub-module, sram_wbuf: the 2-entry FIFO with push, pop, head outputs and a 2-entry address-compare hit output.
- The arbiter proper is grant logic and output muxing.

## Test plan
- Video only: vid_req at adr 18'h37FC0 with sram_din=32'hA5A5_0F0F.
  - Required: sram_adr=18'h37FC0 and vid_data=32'hA5A5_0F0F in the same cycle; sram_we=0.
- CPU write then read of the same address 18'h00100, with ben=4'h3 and data 32'h1234_5678.
  - Required: the write is accepted with no stall; the read stalls exactly 1 cycle while the DRAIN writes with sram_ben=4'h3; then RD is granted.
- Collision: cpu_rd and vid_req in the same cycle.
  - Required: the VID slot is granted, cpu_stall=1 for 1 cycle, then RD; stall_cnt=1.
- Buffer full: three back-to-back cpu_wr while vid_req is held high for 2 cycles.
  - Required: the third write stalls until the first DRAIN; SRAM sees the writes in issue order.
- Reset mid-operation: assert rst=0 with 2 entries buffered.
  - Required: sram_we=0 immediately; after release the buffer is EMPTY, no stale DRAIN occurs, and stall_cnt=0.
- Saturation: force 70000 stalled cycles.
  - Required: stall_cnt=16'hFFFF and it holds that value.
